// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: DOF/EX/WB register addresses,
// branch and multi-cycle status in; stage-register controls and debug stats out.
interface pipe_hazard_ctrl_if;
    logic [4:0]  aa;
    logic [4:0]  ba;
    logic        use_a;
    logic        use_b;
    logic [4:0]  ex_da;
    logic        ex_rw;
    logic [4:0]  wb_da;
    logic        wb_rw;
    logic        br_taken;
    logic        mc_start;
    logic        mc_done;
    logic        hold_pc;
    logic        hold_ir;
    logic        hold_ex;
    logic        bubble_ex;
    logic        flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        err;

    modport master (
        output aa, ba, use_a, use_b, ex_da, ex_rw, wb_da, wb_rw, br_taken, mc_start, mc_done,
        input  hold_pc, hold_ir, hold_ex, bubble_ex, flush, state, stall_cnt, flush_cnt, err
    );

    modport slave (
        input  aa, ba, use_a, use_b, ex_da, ex_rw, wb_da, wb_rw, br_taken, mc_start, mc_done,
        output hold_pc, hold_ir, hold_ex, bubble_ex, flush, state, stall_cnt, flush_cnt, err
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the IF/DOF/EX/WB pipeline: data-hazard stalls, branch
// flushes, multi-cycle waits, plus saturating stall/flush counters and a sticky error flag.
module pipe_hazard_ctrl #(
    parameter int unsigned MAX_STALL  = 4,
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned BR_SLOTS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned     LenW     = $clog2(MAX_STALL + 1);
    localparam int unsigned     TmoW     = $clog2(MC_TIMEOUT + 1);
    localparam logic [1:0]      SlotInit = 2'(BR_SLOTS - 1);
    localparam logic [LenW-1:0] LenMax   = LenW'(MAX_STALL);
    localparam logic [TmoW-1:0] TmoMax   = TmoW'(MC_TIMEOUT);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StStall  = 2'b01,
        StFlush  = 2'b10,
        StMcWait = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [LenW-1:0] len_q, len_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [1:0]      slot_q, slot_d;
    logic [15:0]     stall_cnt_q, flush_cnt_q;
    logic            err_q, err_d;
    logic            hold_pc, hold_ir, hold_ex, bubble_ex, flush, br_accept;
    logic            haz_a, haz_b, haz;

    // Register 0 is hard-wired, so reading it never depends on an in-flight writer.
    assign haz_a = bus.use_a && (bus.aa != 5'd0) &&
                   ((bus.ex_rw && (bus.ex_da == bus.aa)) || (bus.wb_rw && (bus.wb_da == bus.aa)));
    assign haz_b = bus.use_b && (bus.ba != 5'd0) &&
                   ((bus.ex_rw && (bus.ex_da == bus.ba)) || (bus.wb_rw && (bus.wb_da == bus.ba)));
    assign haz   = haz_a || haz_b;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        tmo_d     = tmo_q;
        slot_d    = slot_q;
        err_d     = err_q;
        hold_pc   = 1'b0;
        hold_ir   = 1'b0;
        hold_ex   = 1'b0;
        bubble_ex = 1'b0;
        flush     = 1'b0;
        br_accept = 1'b0;
        unique case (state_q)
            StRun, StStall: begin
                if (bus.br_taken) begin
                    // Branch beats a pending stall or a multi-cycle start in the same cycle.
                    flush     = 1'b1;
                    bubble_ex = 1'b1;
                    br_accept = 1'b1;
                    len_d     = '0;
                    if (BR_SLOTS > 1) begin
                        state_d = StFlush;
                        slot_d  = SlotInit;
                    end else begin
                        state_d = StRun;
                    end
                end else if ((state_q == StRun) && bus.mc_start) begin
                    hold_pc = 1'b1;
                    hold_ir = 1'b1;
                    hold_ex = 1'b1;
                    state_d = StMcWait;
                    tmo_d   = '0;
                end else if (haz) begin
                    hold_pc   = 1'b1;
                    hold_ir   = 1'b1;
                    bubble_ex = 1'b1;
                    state_d   = StStall;
                    if (state_q == StRun) begin
                        len_d = LenW'(1);
                    end else if (len_q < LenMax) begin
                        len_d = len_q + 1'b1;
                    end
                    if (len_d == LenMax) begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = StRun;
                    len_d   = '0;
                end
            end
            StFlush: begin
                flush     = 1'b1;
                bubble_ex = 1'b1;
                slot_d    = slot_q - 1'b1;
                if (slot_d == 2'd0) begin
                    state_d = StRun;
                end
            end
            StMcWait: begin
                hold_pc = 1'b1;
                hold_ir = 1'b1;
                hold_ex = 1'b1;
                tmo_d   = tmo_q + 1'b1;
                if (bus.mc_done) begin
                    state_d = StRun;
                end else if (tmo_d == TmoMax) begin
                    err_d   = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StRun;
            len_q       <= '0;
            tmo_q       <= '0;
            slot_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            tmo_q   <= tmo_d;
            slot_q  <= slot_d;
            err_q   <= err_d;
            if (hold_pc && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (br_accept && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    // Controls are combinational, so gate them directly for an immediate reset response.
    assign bus.hold_pc   = reset & hold_pc;
    assign bus.hold_ir   = reset & hold_ir;
    assign bus.hold_ex   = reset & hold_ex;
    assign bus.bubble_ex = reset & bubble_ex;
    assign bus.flush     = reset & flush;
    assign bus.state     = state_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
    assign bus.err       = err_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the four-stage IF/DOF/EX/WB pipeline.
- Watches DOF source register addresses against the EX and WB destinations, the EX branch decision, and the EX multi-cycle unit.
- Drives hold, bubble and flush controls into the IF, DOF and EX stage registers.
- Keeps saturating stall/flush statistics and a sticky error flag for the team's debug outputs.

Parameters:
MAX_STALL, 4, data-stall cycles after which err is set (a legal data stall is ≤2 cycles).
MC_TIMEOUT, 64, cycles in MC_WAIT before forced exit with err.
BR_SLOTS, 1, consecutive cycles flush is asserted per taken branch (1..3).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
aa  in  5  DOF source A register address
ba  in  5  DOF source B register address
use_a  in  1  DOF instruction reads register A
use_b  in  1  DOF instruction reads register B
ex_da  in  5  EX destination register
ex_rw  in  1  EX instruction writes the register file
wb_da  in  5  WB destination register
wb_rw  in  1  WB instruction writes the register file
br_taken  in  1  EX resolved a taken branch or jump this cycle
mc_start  in  1  EX holds a multi-cycle operation (single-cycle pulse)
mc_done  in  1  multi-cycle result is valid
hold_pc  out  1  PC keeps its value
hold_ir  out  1  IF/DOF register (IR, PC_1) keeps its value
hold_ex  out  1  DOF/EX register keeps its value
bubble_ex  out  1  DOF/EX register loads a NOP (RW=0, MW=0, BS=00)
flush  out  1  IF/DOF register loads a NOP and the PC loads the branch target
state  out  2  00 RUN, 01 STALL, 10 FLUSH, 11 MC_WAIT
stall_cnt  out  16  saturating count of cycles with hold_pc=1
flush_cnt  out  16  saturating count of taken branches
err  out  1  sticky error: stall or multi-cycle timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN; stall_cnt=0, flush_cnt=0, err=0; internal stall and timeout counters = 0.
  - All control outputs are forced 0 while reset=0.
- Data hazard (combinational):
  - hazA = use_a & aa≠0 & ((ex_rw & ex_da==aa) | (wb_rw & wb_da==aa)).
  - hazB is identical using ba/use_b.
  - haz = hazA | hazB. Register 0 never causes a hazard.
- Control outputs are combinational from state and inputs. Priority is reset > flush > MC_WAIT > data hazard.
- RUN:
  - br_taken=1: flush=1, bubble_ex=1, flush_cnt++.
    - BR_SLOTS>1: go to FLUSH with slot counter = BR_SLOTS-1.
    - BR_SLOTS=1: stay in RUN.
  - else mc_start=1: hold_pc=hold_ir=hold_ex=1; go to MC_WAIT and clear the timeout counter.
  - else haz=1: hold_pc=hold_ir=1, bubble_ex=1; go to STALL with stall length = 1.
  - else all controls 0.
- STALL:
  - br_taken=1: flush behaviour as in RUN; the stall is abandoned.
  - haz=1: hold_pc=hold_ir=bubble_ex=1; stall length++.
    - Stall length reaching MAX_STALL sets err=1; the state stays in STALL.
  - haz=0: all controls 0 this cycle; return to RUN.
- FLUSH:
  - flush=1, bubble_ex=1 each cycle; decrement the slot counter; return to RUN at 0.
  - br_taken is ignored in FLUSH because the EX stage holds a bubble.
- MC_WAIT:
  - hold_pc=hold_ir=hold_ex=1 every cycle, including the cycle mc_done=1.
  - mc_done=1: return to RUN. The EX result is written on that edge and the pipeline resumes next cycle.
  - Timeout counter reaching MC_TIMEOUT: set err=1, return to RUN.
  - br_taken and haz are ignored in MC_WAIT.
- mc_start and br_taken in the same cycle: the branch wins and the multi-cycle operation is not waited on.
- stall_cnt increments on each clock edge where hold_pc=1; it saturates at 16'hFFFF.
- flush_cnt increments once per taken branch (not per flush slot); it saturates at 16'hFFFF.
- err clears only on reset.
- Reset asserted mid-STALL, mid-FLUSH or mid-MC_WAIT returns to RUN immediately. Outputs go to 0 without waiting for a clock edge.

Test Plan:
- Reset release, all inputs 0 → state=00, every control output 0, counters 0, err=0 for 10 cycles.
- ex_da=5, ex_rw=1, aa=5, use_a=1 for cycle 1, then wb_da=5, wb_rw=1 for cycle 2 (EX writer moved on) → hold_pc=hold_ir=bubble_ex=1 for 2 cycles, state 01, then RUN; stall_cnt=2.
- aa=0, use_a=1, ex_da=0, ex_rw=1 → no stall. use_b=0 with ba matching ex_da → no stall.
- br_taken=1 while in STALL, BR_SLOTS=2 → flush=1 for 2 cycles, state 10 in the second cycle, then RUN; flush_cnt=1; the stall is dropped.
- mc_start pulse, mc_done after 5 cycles → hold_pc/hold_ir/hold_ex=1 for 6 cycles, state 11, then RUN; stall_cnt=6, err=0.
- mc_start with no mc_done, MC_TIMEOUT=64 → err=1 after 64 cycles and RUN. Then a hazard held 4 cycles with MAX_STALL=4 → err stays 1. Asynchronous reset mid-stall → all outputs 0 immediately, err=0.
